// File: rtl/soda_buyer.sv
// Customer-side coin driver for the vending machine interface.
// Picks a coin plan from the wallet, inserts it, and banks returned change.
module soda_buyer #(
    parameter int CNT_W       = 4,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_ones,
    input  logic [CNT_W-1:0] load_twos,
    input  logic [CNT_W-1:0] load_fives,
    input  logic             buy,
    input  logic             soda,
    input  logic [1:0]       coin_out,
    output logic [1:0]       coin_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             err_code,
    output logic [2:0]       change_total,
    output logic [CNT_W-1:0] ones,
    output logic [CNT_W-1:0] twos,
    output logic [CNT_W-1:0] fives
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INS1,
        S_INS2,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state, state_n;
    logic [1:0]       coin_n;
    logic             pair, pair_n;
    logic [TW-1:0]    cnt, cnt_n;
    logic             code_n;
    logic [2:0]       chg_n;
    logic [CNT_W-1:0] ones_n, twos_n, fives_n;
    logic             dec1, dec2, dec5;
    logic             inc1, inc2;
    logic             take;

    // Decrement and saturating increment in one step; both together cancel.
    function automatic logic [CNT_W-1:0] bump(
        input logic [CNT_W-1:0] v,
        input logic             dec,
        input logic             inc
    );
        logic [CNT_W-1:0] r;
        r = v;
        if (dec && !inc) begin
            r = v - CNT_W'(1);
        end else if (inc && !dec && v != CNT_MAX) begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    always_comb begin
        state_n = state;
        coin_n  = 2'b00;
        pair_n  = pair;
        cnt_n   = cnt;
        code_n  = err_code;
        chg_n   = change_total;
        dec1    = 1'b0;
        dec2    = 1'b0;
        dec5    = 1'b0;
        inc1    = 1'b0;
        inc2    = 1'b0;
        take    = 1'b0;
        ones_n  = ones;
        twos_n  = twos;
        fives_n = fives;

        if (state inside {S_INS1, S_INS2, S_WAIT}) begin
            inc1 = (coin_out == 2'b01);
            inc2 = (coin_out == 2'b10);
        end

        unique case (state)
            S_IDLE: begin
                if (load) begin
                    take = 1'b1;
                end else if (buy) begin
                    if (twos != '0) begin
                        dec2    = 1'b1;
                        coin_n  = 2'b10;
                        pair_n  = 1'b0;
                        chg_n   = '0;
                        state_n = S_INS1;
                    end else if (ones >= CNT_W'(2)) begin
                        dec1    = 1'b1;
                        coin_n  = 2'b01;
                        pair_n  = 1'b1;
                        chg_n   = '0;
                        state_n = S_INS1;
                    end else if (fives != '0) begin
                        dec5    = 1'b1;
                        coin_n  = 2'b11;
                        pair_n  = 1'b0;
                        chg_n   = '0;
                        state_n = S_INS1;
                    end else begin
                        code_n  = 1'b0;
                        state_n = S_ERR;
                    end
                end
            end
            S_INS1: begin
                if (pair) begin
                    dec1    = 1'b1;
                    coin_n  = 2'b01;
                    state_n = S_INS2;
                end else begin
                    cnt_n   = '0;
                    state_n = S_WAIT;
                end
            end
            S_INS2: begin
                cnt_n   = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (soda) begin
                    state_n = S_DONE;
                end else if (cnt == CNT_LAST) begin
                    code_n  = 1'b1;
                    state_n = S_ERR;
                end else begin
                    cnt_n = cnt + TW'(1);
                end
            end
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Change is worth 1 or 2 units; a 11 code from the machine is noise.
        chg_n = chg_n + {inc2, inc1};

        if (take) begin
            ones_n  = load_ones;
            twos_n  = load_twos;
            fives_n = load_fives;
        end else begin
            ones_n  = bump(ones, dec1, inc1);
            twos_n  = bump(twos, dec2, inc2);
            fives_n = bump(fives, dec5, 1'b0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            coin_in      <= 2'b00;
            pair         <= 1'b0;
            cnt          <= '0;
            err_code     <= 1'b0;
            change_total <= '0;
            ones         <= '0;
            twos         <= '0;
            fives        <= '0;
        end else begin
            state        <= state_n;
            coin_in      <= coin_n;
            pair         <= pair_n;
            cnt          <= cnt_n;
            err_code     <= code_n;
            change_total <= chg_n;
            ones         <= ones_n;
            twos         <= twos_n;
            fives        <= fives_n;
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign err  = (state == S_ERR);

endmodule

// File: tb/tb_soda_buyer.sv
// Bench for soda_buyer: directed purchases plus randomized wallets,
// machine change and soda timing against a transaction-level model.
module tb_soda_buyer;

    localparam int CNT_W = 4;
    localparam int TOUT  = 8;
    localparam int MAXC  = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [CNT_W-1:0] load_ones, load_twos, load_fives;
    logic             buy;
    logic             soda;
    logic [1:0]       coin_out;
    logic [1:0]       coin_in;
    logic             busy, done, err, err_code;
    logic [2:0]       change_total;
    logic [CNT_W-1:0] ones, twos, fives;

    int checks   = 0;
    int failures = 0;
    int m_ones, m_twos, m_fives, m_chg, m_code;
    logic [1:0] co_sched [0:31];

    always #5 clk = ~clk;

    soda_buyer #(.CNT_W(CNT_W), .TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .reset(reset), .load(load),
        .load_ones(load_ones), .load_twos(load_twos),
        .load_fives(load_fives), .buy(buy), .soda(soda),
        .coin_out(coin_out), .coin_in(coin_in), .busy(busy),
        .done(done), .err(err), .err_code(err_code),
        .change_total(change_total), .ones(ones), .twos(twos),
        .fives(fives)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic clear_sched();
        for (int i = 0; i < 32; i++) co_sched[i] = 2'b00;
    endtask

    task automatic rand_sched();
        for (int i = 0; i < 32; i++) begin
            co_sched[i] = ($urandom_range(0, 2) == 0) ? 2'(
                $urandom_range(1, 3)) : 2'b00;
        end
    endtask

    task automatic check_wallet(input string tag);
        chk({tag, ".ones"}, ones, m_ones);
        chk({tag, ".twos"}, twos, m_twos);
        chk({tag, ".fives"}, fives, m_fives);
        chk({tag, ".change"}, change_total, m_chg);
        chk({tag, ".err_code"}, err_code, m_code);
    endtask

    // One purchase. s = cycle (1 = first coin cycle) of the soda pulse,
    // 0 = never. noise adds load/buy strobes while busy.
    task automatic txn(input string tag, input bit do_load, input int lo,
                       input int lt, input int lf, input int s,
                       input bit noise);
        int nc, d1, d2, d5, e, n1, n2;
        bit ok, is_done;
        logic [1:0] code;
        @(negedge clk);
        if (do_load) begin
            load = 1'b1;
            load_ones = 4'(lo);
            load_twos = 4'(lt);
            load_fives = 4'(lf);
            m_ones = lo;
            m_twos = lt;
            m_fives = lf;
        end
        @(negedge clk);
        load = 1'b0;
        buy = 1'b1;
        ok = 1'b1;
        d1 = 0; d2 = 0; d5 = 0; nc = 0; code = 2'b00;
        if (m_twos >= 1) begin
            nc = 1; d2 = 1; code = 2'b10;
        end else if (m_ones >= 2) begin
            nc = 2; d1 = 2; code = 2'b01;
        end else if (m_fives >= 1) begin
            nc = 1; d5 = 1; code = 2'b11;
        end else begin
            ok = 1'b0;
        end
        if (!ok) e = 1;
        else if (s > nc && s <= nc + TOUT) e = s + 1;
        else e = nc + TOUT + 1;
        is_done = ok && (e == s + 1);
        n1 = 0;
        n2 = 0;
        for (int j = 1; j <= e + 1; j++) begin
            @(negedge clk);
            buy = 1'b0;
            load = 1'b0;
            soda = 1'b0;
            coin_out = 2'b00;
            chk({tag, ".coin_in"}, coin_in, (j <= nc) ? code : 2'b00);
            chk({tag, ".busy"}, busy, (j <= e) ? 1 : 0);
            chk({tag, ".done"}, done, (is_done && j == e) ? 1 : 0);
            chk({tag, ".err"}, err, (!is_done && j == e) ? 1 : 0);
            if (j == e && !is_done) chk({tag, ".code"}, err_code, ok);
            if (j <= e) begin
                coin_out = co_sched[j];
                if (j < e && co_sched[j] == 2'b01) n1++;
                if (j < e && co_sched[j] == 2'b10) n2++;
                soda = (j == s);
                if (noise && j == 1) begin
                    load = 1'b1;
                    buy = 1'b1;
                    load_ones = 4'($urandom);
                    load_twos = 4'($urandom);
                    load_fives = 4'($urandom);
                end
            end
        end
        soda = 1'b0;
        coin_out = 2'b00;
        load = 1'b0;
        buy = 1'b0;
        if (ok) begin
            m_ones = imin(MAXC, m_ones - d1 + n1);
            m_twos = imin(MAXC, m_twos - d2 + n2);
            m_fives = m_fives - d5;
            m_chg = (n1 + 2 * n2) % 8;
            if (!is_done) m_code = 1;
        end else begin
            m_code = 0;
        end
        check_wallet(tag);
    endtask

    initial begin
        reset = 1'b1;
        load = 1'b0;
        buy = 1'b0;
        soda = 1'b0;
        coin_out = 2'b00;
        load_ones = '0;
        load_twos = '0;
        load_fives = '0;
        m_ones = 0; m_twos = 0; m_fives = 0; m_chg = 0; m_code = 0;
        clear_sched();
        repeat (2) @(negedge clk);
        chk("rst.coin_in", coin_in, 2'b00);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.err", err, 0);
        check_wallet("rst");
        reset = 1'b0;

        clear_sched();
        txn("two", 1'b1, 0, 1, 0, 3, 1'b0);
        txn("pair", 1'b1, 3, 0, 0, 4, 1'b0);
        co_sched[2] = 2'b10;
        co_sched[3] = 2'b01;
        txn("five", 1'b1, 0, 0, 1, 4, 1'b0);
        clear_sched();
        txn("nofund", 1'b1, 1, 0, 0, 0, 1'b0);
        txn("tmo", 1'b1, 0, 1, 0, 0, 1'b0);
        for (int i = 1; i < 12; i++) co_sched[i] = 2'b01;
        txn("sat", 1'b1, 15, 1, 0, 0, 1'b0);
        clear_sched();

        @(negedge clk);
        load = 1'b1;
        buy = 1'b1;
        load_ones = 4'd0;
        load_twos = 4'd2;
        load_fives = 4'd0;
        m_ones = 0; m_twos = 2; m_fives = 0;
        @(negedge clk);
        load = 1'b0;
        buy = 1'b0;
        chk("ldbuy.busy", busy, 0);
        chk("ldbuy.coin_in", coin_in, 2'b00);
        check_wallet("ldbuy");
        @(negedge clk);
        chk("ldbuy.busy2", busy, 0);

        @(negedge clk);
        load = 1'b1;
        load_ones = 4'd1;
        load_twos = 4'd0;
        load_fives = 4'd2;
        @(negedge clk);
        load = 1'b0;
        buy = 1'b1;
        @(negedge clk);
        buy = 1'b0;
        chk("rmid.coin_in", coin_in, 2'b11);
        @(negedge clk);
        chk("rmid.busy_wait", busy, 1);
        coin_out = 2'b01;
        soda = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        soda = 1'b0;
        coin_out = 2'b00;
        m_ones = 0; m_twos = 0; m_fives = 0; m_chg = 0; m_code = 0;
        chk("rmid.busy", busy, 0);
        chk("rmid.coin_in", coin_in, 2'b00);
        chk("rmid.done", done, 0);
        chk("rmid.err", err, 0);
        check_wallet("rmid");
        @(negedge clk);
        chk("rmid.done2", done, 0);
        chk("rmid.err2", err, 0);

        for (int t = 0; t < 40; t++) begin
            int lo, lt, lf;
            lo = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            lt = $urandom_range(0, 1);
            lf = $urandom_range(0, 2);
            rand_sched();
            txn("rnd", ($urandom_range(0, 3) != 0), lo, lt, lf,
                $urandom_range(0, 12), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
